calc_frame_engine: RTL and testbench
====================================

CALC_FRAME_ENGINE -- requirements
Module: calc_frame_engine

Interface
REQ-001 Parameter WIDTH, default 8: operand/result width in bits; SHALL be a multiple of 8 (8, 16, 32); BYTES = WIDTH/8.
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000: maximum idle cycles between bytes inside a frame; 0 disables the timeout.
REQ-003 CLK  input  1  single clock, all logic on rising edge; one clock, reset asynchronous and active-high.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 rx_data  input  8  received byte from the UART receiver.
REQ-006 rx_valid  input  1  rx_data holds an unconsumed byte; held until acknowledged.
REQ-007 rx_ack  output  1  one-cycle pulse consuming the current rx_data.
REQ-008 tx_data  output  8  byte to transmit; valid when tx_start is high.
REQ-009 tx_start  output  1  one-cycle transmit request.
REQ-010 tx_busy  input  1  transmitter busy; high from the cycle after tx_start until the byte is sent.
REQ-011 busy  output  1  high in every state except OP1 with no byte received.
REQ-012 frame_err  output  1  one-cycle pulse on inter-byte timeout.

Function
REQ-013 Frame in: BYTES bytes op1 (MSB first), 1 opcode byte, BYTES bytes op2 (MSB first); frame length is fixed regardless of opcode validity.
REQ-014 States: OP1 -> OPCODE -> OP2 -> EXEC -> SEND -> OP1; OP1/OP2 advance after their BYTES-th byte, OPCODE after one byte.
REQ-015 A byte is sampled when rx_valid=1 and rx_ack=0 in OP1/OPCODE/OP2; rx_ack pulses in the next cycle; rx_valid is not sampled while rx_ack=1; rx_ack never asserts in EXEC/SEND.
REQ-016 Opcodes (ASCII): '+'=0x2B add, '-'=0x2D sub, 'x'=0x78 mul, '/'=0x2F div; any other byte is invalid.
REQ-017 All arithmetic unsigned; result truncated to WIDTH bits.
REQ-018 Add: status 0x03 if carry-out, else 0x00.
REQ-019 Sub: status 0x03 if op2 > op1 (borrow), else 0x00; result = (op1 - op2) mod 2^WIDTH.
REQ-020 Mul: full 2*WIDTH product; result = low half; status 0x03 if high half nonzero.
REQ-021 Div: quotient by sequential restoring divider, one quotient bit per cycle; op2=0 -> result all ones, status 0x01, no iteration.
REQ-022 Invalid opcode: result 0, status 0x02.
REQ-023 EXEC latency: 1 cycle for add/sub/mul/invalid/div-by-zero; WIDTH+1 cycles for div.
REQ-024 Response: status byte, then BYTES result bytes MSB first; 1+BYTES tx_start pulses.
REQ-025 tx_start issued only when tx_busy=0 and no tx_start in the previous cycle.
REQ-026 After the last response byte's tx_start, return to OP1; the next frame may be received while that byte is transmitting.
REQ-027 Timeout: in OP1 (after >=1 byte), OPCODE or OP2, an idle counter counts cycles without a sampled byte, resets on each sampled byte; on reaching TIMEOUT_CYCLES pulse frame_err, discard partial frame, go to OP1, send nothing.
REQ-028 Timeout is inactive in OP1 before the first byte, in EXEC and in SEND.
REQ-029 rx_valid during EXEC/SEND is left pending and is consumed after return to OP1.

Reset
REQ-030 RST=1 forces immediately: state OP1, rx_ack=0, tx_start=0, tx_data=0x00, busy=0, frame_err=0, operand/opcode/result/status registers 0, idle and byte counters 0.
REQ-031 Reset mid-frame or mid-response aborts without further tx_start; the first byte after release is op1 MSB.

Configuration
REQ-032 Macro CALC_MOD_EN: when defined, opcode '%'=0x25 computes remainder from the same divider, same latency, op2=0 -> result = op1, status 0x01.
REQ-033 Without CALC_MOD_EN, '%' is an invalid opcode (status 0x02, result 0) and no remainder output logic exists.

Verification
REQ-034 WIDTH=8: bytes 0x07,'+',0x05 -> tx 0x00,0x0C; rx_ack pulses 3, one per byte.
REQ-035 WIDTH=16: 0x12,0x34,'/',0x00,0x10 -> EXEC 17 cycles -> tx 0x00,0x01,0x23.
REQ-036 WIDTH=8: 0xFF,'x',0x02 -> tx 0x03,0xFE; 0x09,'/',0x00 -> tx 0x01,0xFF; 0x09,'?',0x01 -> tx 0x02,0x00.
REQ-037 TIMEOUT_CYCLES=100: 0x07,'+' then idle 100 cycles -> one frame_err pulse, no tx_start; then 0x01,'-',0x02 -> tx 0x03,0xFF.
REQ-038 RST pulse after first status tx_start -> no further tx_start, all outputs 0; then 0x03,'+',0x04 -> tx 0x00,0x07.
REQ-039 CALC_MOD_EN defined: 0x11,'%',0x05 -> tx 0x00,0x02; undefined: same -> tx 0x02,0x00.

Source files
------------

// File: rtl/calc_frame_engine.sv
// calc_frame_engine: byte-framed unsigned calculator (op1, opcode, op2 in; status + result out).
// Ports: CLK/RST (async high), rx_data/rx_valid/rx_ack (UART rx side), tx_data/tx_start/tx_busy
// (UART tx side), busy, frame_err. Optional macro CALC_MOD_EN enables the '%' remainder opcode.
module calc_frame_engine #(
  parameter int WIDTH          = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ack,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic       busy,
  output logic       frame_err
);

  localparam int BYTES = WIDTH / 8;
  localparam int CW    = $clog2(BYTES + 2);
  localparam int IW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int DW    = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_OP1, S_OPC, S_OP2, S_EXEC, S_SEND
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idle_q, idle_d;
  logic [WIDTH-1:0] op1_q, op1_d;
  logic [WIDTH-1:0] op2_q, op2_d;
  logic [7:0]       opc_q, opc_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [7:0]       st_q, st_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic             drun_q, drun_d;
  logic             rx_ack_q, rx_ack_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             ferr_q, ferr_d;

  logic                   sample, rx_phase, ge;
  logic [WIDTH:0]         sum_w, rsh_w, trial_w;
  logic [2*WIDTH-1:0]     prod_w;
  logic [7:0]             res_byte;

  assign sample = rx_valid && !rx_ack_q &&
                  (state_q == S_OP1 || state_q == S_OPC || state_q == S_OP2);
  // Idle timeout only runs once a frame has actually started.
  assign rx_phase = (state_q == S_OP1 && cnt_q != '0) ||
                    state_q == S_OPC || state_q == S_OP2;

  assign sum_w  = {1'b0, op1_q} + {1'b0, op2_q};
  assign prod_w = {{WIDTH{1'b0}}, op1_q} * {{WIDTH{1'b0}}, op2_q};

  // Restoring divider step: shift next dividend bit into the partial remainder.
  assign rsh_w   = {rem_q, quo_q[WIDTH-1]};
  assign trial_w = rsh_w - {1'b0, op2_q};
  assign ge      = ~trial_w[WIDTH];

  // cnt_q = k (1..BYTES) selects result byte k, MSB first.
  always_comb begin
    res_byte = '0;
    for (int k = 0; k < BYTES; k++)
      if (cnt_q == CW'(BYTES - k)) res_byte = res_q[8*k +: 8];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idle_d     = idle_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    opc_d      = opc_q;
    res_d      = res_q;
    st_d       = st_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dcnt_d     = dcnt_q;
    drun_d     = drun_q;
    rx_ack_d   = 1'b0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    ferr_d     = 1'b0;

    unique case (state_q)
      S_OP1: begin
        if (sample) begin
          op1_d = (op1_q << 8) | WIDTH'(rx_data);
          if (cnt_q == CW'(BYTES - 1)) begin
            cnt_d   = '0;
            state_d = S_OPC;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_OPC: begin
        if (sample) begin
          opc_d   = rx_data;
          state_d = S_OP2;
        end
      end
      S_OP2: begin
        if (sample) begin
          op2_d = (op2_q << 8) | WIDTH'(rx_data);
          if (cnt_q == CW'(BYTES - 1)) begin
            cnt_d   = '0;
            drun_d  = 1'b0;
            state_d = S_EXEC;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_EXEC: begin
        if (!drun_q) begin
          state_d = S_SEND;
          cnt_d   = '0;
          case (opc_q)
            8'h2B: begin
              res_d = sum_w[WIDTH-1:0];
              st_d  = sum_w[WIDTH] ? 8'h03 : 8'h00;
            end
            8'h2D: begin
              res_d = op1_q - op2_q;
              st_d  = (op2_q > op1_q) ? 8'h03 : 8'h00;
            end
            8'h78: begin
              res_d = prod_w[WIDTH-1:0];
              st_d  = (|prod_w[2*WIDTH-1:WIDTH]) ? 8'h03 : 8'h00;
            end
            8'h2F: begin
              if (op2_q == '0) begin
                res_d = '1;
                st_d  = 8'h01;
              end else begin
                state_d = S_EXEC;
                rem_d   = '0;
                quo_d   = op1_q;
                dcnt_d  = DW'(WIDTH);
                drun_d  = 1'b1;
              end
            end
`ifdef CALC_MOD_EN
            8'h25: begin
              if (op2_q == '0) begin
                res_d = op1_q;
                st_d  = 8'h01;
              end else begin
                state_d = S_EXEC;
                rem_d   = '0;
                quo_d   = op1_q;
                dcnt_d  = DW'(WIDTH);
                drun_d  = 1'b1;
              end
            end
`endif
            default: begin
              res_d = '0;
              st_d  = 8'h02;
            end
          endcase
        end else begin
          rem_d  = ge ? trial_w[WIDTH-1:0] : rsh_w[WIDTH-1:0];
          quo_d  = {quo_q[WIDTH-2:0], ge};
          dcnt_d = dcnt_q - 1'b1;
          if (dcnt_q == DW'(1)) begin
            drun_d  = 1'b0;
            state_d = S_SEND;
            cnt_d   = '0;
            st_d    = 8'h00;
            res_d   = quo_d;
`ifdef CALC_MOD_EN
            if (opc_q == 8'h25) res_d = rem_d;
`endif
          end
        end
      end
      S_SEND: begin
        // Back-to-back starts are blocked so tx_busy has a cycle to rise.
        if (!tx_busy && !tx_start_q) begin
          tx_start_d = 1'b1;
          tx_data_d  = (cnt_q == '0) ? st_q : res_byte;
          if (cnt_q == CW'(BYTES)) begin
            cnt_d   = '0;
            state_d = S_OP1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_OP1;
    endcase

    if (sample) begin
      rx_ack_d = 1'b1;
      idle_d   = '0;
    end else if (rx_phase && TIMEOUT_CYCLES != 0) begin
      idle_d = idle_q + 1'b1;
      if (idle_d == IW'(TIMEOUT_CYCLES)) begin
        ferr_d  = 1'b1;
        state_d = S_OP1;
        cnt_d   = '0;
        idle_d  = '0;
        op1_d   = '0;
        op2_d   = '0;
        opc_d   = '0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_OP1;
      cnt_q      <= '0;
      idle_q     <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      opc_q      <= '0;
      res_q      <= '0;
      st_q       <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dcnt_q     <= '0;
      drun_q     <= 1'b0;
      rx_ack_q   <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idle_q     <= idle_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      opc_q      <= opc_d;
      res_q      <= res_d;
      st_q       <= st_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dcnt_q     <= dcnt_d;
      drun_q     <= drun_d;
      rx_ack_q   <= rx_ack_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      ferr_q     <= ferr_d;
    end
  end

  assign rx_ack    = rx_ack_q;
  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign frame_err = ferr_q;
  assign busy      = !(state_q == S_OP1 && cnt_q == '0);

endmodule

// File: tb/tb_calc_frame_engine.sv
// tb_calc_frame_engine: directed checks of calc_frame_engine.
// DUT a: WIDTH=8, TIMEOUT_CYCLES=100. DUT b: WIDTH=16, default timeout.
module tb_calc_frame_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] a_rxd, a_txd, b_rxd, b_txd;
  logic a_rxv, a_ack, a_txs, a_txb, a_busy, a_ferr;
  logic b_rxv, b_ack, b_txs, b_txb, b_busy, b_ferr;

  calc_frame_engine #(.WIDTH(8), .TIMEOUT_CYCLES(100)) u_a (
    .CLK(clk), .RST(rst), .rx_data(a_rxd), .rx_valid(a_rxv),
    .rx_ack(a_ack), .tx_data(a_txd), .tx_start(a_txs),
    .tx_busy(a_txb), .busy(a_busy), .frame_err(a_ferr)
  );

  calc_frame_engine #(.WIDTH(16)) u_b (
    .CLK(clk), .RST(rst), .rx_data(b_rxd), .rx_valid(b_rxv),
    .rx_ack(b_ack), .tx_data(b_txd), .tx_start(b_txs),
    .tx_busy(b_txb), .busy(b_busy), .frame_err(b_ferr)
  );

`ifdef CALC_MOD_EN
  localparam logic [7:0] MOD_S = 8'h00;
  localparam logic [7:0] MOD_R = 8'h02;
`else
  localparam logic [7:0] MOD_S = 8'h02;
  localparam logic [7:0] MOD_R = 8'h00;
`endif

  int ncmp = 0;
  int nerr = 0;
  int cyc = 0;
  int a_nack = 0, a_nerr = 0, a_ackc = 0;
  int b_nack = 0, b_nerr = 0, b_ackc = 0;
  logic [7:0] a_q[$], b_q[$];
  int a_tc[$], b_tc[$];
  logic [2:0] a_bc, b_bc;

  always @(posedge clk) cyc <= cyc + 1;

  // Simple transmitter models: busy for 4 cycles after each start.
  always @(posedge clk or posedge rst)
    if (rst) a_bc <= '0;
    else if (a_txs) a_bc <= 3'd4;
    else if (a_bc != 0) a_bc <= a_bc - 1'b1;
  always @(posedge clk or posedge rst)
    if (rst) b_bc <= '0;
    else if (b_txs) b_bc <= 3'd4;
    else if (b_bc != 0) b_bc <= b_bc - 1'b1;
  assign a_txb = (a_bc != 0);
  assign b_txb = (b_bc != 0);

  always @(negedge clk) begin
    if (a_ack) begin a_nack++; a_ackc = cyc; end
    if (b_ack) begin b_nack++; b_ackc = cyc; end
    if (a_ferr) a_nerr++;
    if (b_ferr) b_nerr++;
    if (a_txs) begin a_q.push_back(a_txd); a_tc.push_back(cyc); end
    if (b_txs) begin b_q.push_back(b_txd); b_tc.push_back(cyc); end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input bit sel, input logic [7:0] d);
    int n = 0;
    bit got = 1'b0;
    @(negedge clk);
    if (sel) begin b_rxd = d; b_rxv = 1'b1; end
    else begin a_rxd = d; a_rxv = 1'b1; end
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      got = sel ? b_ack : a_ack;
    end
    if (sel) b_rxv = 1'b0; else a_rxv = 1'b0;
    chk(sel ? "b rx_ack seen" : "a rx_ack seen", 32'(got), 1);
  endtask

  task automatic wait_tx(input bit sel, input int n);
    int k = 0;
    while ((sel ? b_q.size() : a_q.size()) < n && k < 400) begin
      @(negedge clk);
      k++;
    end
    repeat (10) @(negedge clk);
    chk(sel ? "b tx count" : "a tx count",
        sel ? b_q.size() : a_q.size(), n);
  endtask

  task automatic frame8(input string tag, input logic [7:0] x, o, y,
                        input logic [7:0] e0, e1, input int lat);
    logic [7:0] g0, g1;
    int l;
    a_q.delete();
    a_tc.delete();
    send(0, x);
    send(0, o);
    send(0, y);
    wait_tx(0, 2);
    g0 = (a_q.size() > 0) ? a_q[0] : 8'hxx;
    g1 = (a_q.size() > 1) ? a_q[1] : 8'hxx;
    l  = (a_tc.size() > 0) ? a_tc[0] - a_ackc : -1;
    chk({tag, " status"}, g0, e0);
    chk({tag, " result"}, g1, e1);
    if (lat > 0) chk({tag, " latency"}, l, lat);
  endtask

  initial begin
    logic [7:0] g0, g1, g2;
    int n0, k;
    a_rxv = 1'b0; a_rxd = '0;
    b_rxv = 1'b0; b_rxd = '0;
    repeat (3) @(negedge clk);
    chk("rst rx_ack", a_ack, 0);
    chk("rst tx_start", a_txs, 0);
    chk("rst tx_data", a_txd, 0);
    chk("rst busy", a_busy, 0);
    chk("rst frame_err", a_ferr, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    n0 = a_nack;
    a_q.delete();
    a_tc.delete();
    send(0, 8'h07);
    chk("busy after op1", a_busy, 1);
    send(0, 8'h2B);
    send(0, 8'h05);
    wait_tx(0, 2);
    g0 = (a_q.size() > 0) ? a_q[0] : 8'hxx;
    g1 = (a_q.size() > 1) ? a_q[1] : 8'hxx;
    chk("add status", g0, 8'h00);
    chk("add result", g1, 8'h0C);
    chk("add latency", (a_tc.size() > 0) ? a_tc[0] - a_ackc : -1, 2);
    chk("add ack count", a_nack - n0, 3);
    chk("busy idle", a_busy, 0);

    frame8("add carry", 8'hF0, 8'h2B, 8'h20, 8'h03, 8'h10, 0);
    frame8("mul ovf", 8'hFF, 8'h78, 8'h02, 8'h03, 8'hFE, 2);
    frame8("div zero", 8'h09, 8'h2F, 8'h00, 8'h01, 8'hFF, 2);
    frame8("invalid", 8'h09, 8'h3F, 8'h01, 8'h02, 8'h00, 2);
    frame8("div8", 8'hC8, 8'h2F, 8'h07, 8'h00, 8'h1C, 10);
    frame8("sub", 8'h09, 8'h2D, 8'h04, 8'h00, 8'h05, 0);
    frame8("mod", 8'h11, 8'h25, 8'h05, MOD_S, MOD_R, 0);

    b_q.delete();
    b_tc.delete();
    send(1, 8'h12);
    send(1, 8'h34);
    send(1, 8'h2F);
    send(1, 8'h00);
    send(1, 8'h10);
    wait_tx(1, 3);
    g0 = (b_q.size() > 0) ? b_q[0] : 8'hxx;
    g1 = (b_q.size() > 1) ? b_q[1] : 8'hxx;
    g2 = (b_q.size() > 2) ? b_q[2] : 8'hxx;
    chk("div16 status", g0, 8'h00);
    chk("div16 msb", g1, 8'h01);
    chk("div16 lsb", g2, 8'h23);
    chk("div16 latency", (b_tc.size() > 0) ? b_tc[0] - b_ackc : -1, 18);

    a_q.delete();
    n0 = a_nerr;
    send(0, 8'h07);
    send(0, 8'h2B);
    repeat (150) @(negedge clk);
    chk("timeout frame_err", a_nerr - n0, 1);
    chk("timeout no tx", a_q.size(), 0);
    chk("timeout busy", a_busy, 0);
    frame8("sub borrow", 8'h01, 8'h2D, 8'h02, 8'h03, 8'hFF, 0);

    a_q.delete();
    send(0, 8'h05);
    send(0, 8'h2B);
    send(0, 8'h06);
    k = 0;
    while (a_q.size() < 1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("mid rst rx_ack", a_ack, 0);
    chk("mid rst tx_start", a_txs, 0);
    chk("mid rst tx_data", a_txd, 0);
    chk("mid rst busy", a_busy, 0);
    chk("mid rst frame_err", a_ferr, 0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("mid rst tx count", a_q.size(), 1);
    frame8("after rst", 8'h03, 8'h2B, 8'h04, 8'h00, 8'h07, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
